// File: rtl/sensor_client_pkg.sv
// Purpose : shared state encoding and request codes for the sensor client and RequestHandler.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package sensor_client_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND_CMD  = 3'd1,
    WAIT_CMD  = 3'd2,
    SEND_ADDR = 3'd3,
    WAIT_ADDR = 3'd4,
    WAIT_CODE = 3'd5,
    WAIT_DATA = 3'd6,
    DONE      = 3'd7
  } state_e;

  // Request codes understood by the remote RequestHandler.
  localparam logic [7:0] CMD_TEMPERATURE = 8'h01;
  localparam logic [7:0] CMD_HUMIDITY    = 8'h02;
  localparam logic [7:0] CMD_STATUS      = 8'h03;

  // States in which the client is waiting on the UART and the abort timer runs.
  function automatic logic is_wait_state(input state_e s);
    return (s == WAIT_CMD) || (s == WAIT_ADDR) || (s == WAIT_CODE) || (s == WAIT_DATA);
  endfunction

endpackage

// File: rtl/sensor_client_if.sv
// Purpose : groups the request, UART TX/RX and response signals of the sensor client.
// Latency : n/a (wires only).
// Backpressure: none; all strobes are single-cycle pulses.
// Ports   : slave = client side (drives busy/tx/response/timeout),
//           master = environment side (drives start/command/address/tx_done/rx).
interface sensor_client_if;
  logic       start;
  logic [7:0] command;
  logic [7:0] address;
  logic       busy;
  logic       tx_has_data;
  logic [7:0] tx_data;
  logic       tx_done;
  logic       rx_has_data;
  logic [7:0] rx_data;
  logic       response_valid;
  logic [7:0] response_code;
  logic [7:0] response_data;
  logic       timeout;

  modport master (
    output start, command, address, tx_done, rx_has_data, rx_data,
    input  busy, tx_has_data, tx_data, response_valid, response_code, response_data, timeout
  );

  modport slave (
    input  start, command, address, tx_done, rx_has_data, rx_data,
    output busy, tx_has_data, tx_data, response_valid, response_code, response_data, timeout
  );
endinterface

// File: rtl/sensor_client_timeout_counter.sv
// Purpose : saturating wait-state timer with terminal-count flag.
// Latency : terminal is combinational from the count register.
// Backpressure: none.
// Ports   : clock, reset_n (sync, active-low), clear, enable -> terminal (count == TIMEOUT_CYCLES-1).
module sensor_client_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 50000000,
  parameter int CNT_W          = 26
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Clear has priority so a state change always restarts the wait from zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign terminal = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/sensor_client.sv
// Purpose : sends command+address bytes over UART TX, collects code+data bytes from UART RX.
// Latency : response_valid one cycle after the edge that captures the second rx byte.
// Backpressure: none; start ignored while busy, waits abort after TIMEOUT_CYCLES.
// Ports   : clock, reset_n (sync, active-low), bus (sensor_client_if.slave).
module sensor_client
  import sensor_client_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000000,
  parameter int CNT_W          = 26
) (
  input  logic            clock,
  input  logic            reset_n,
  sensor_client_if.slave  bus
);

  state_e     state_q, state_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic [7:0] code_stage_q, code_stage_d;
  logic [7:0] resp_code_q, resp_code_d;
  logic [7:0] resp_data_q, resp_data_d;
  logic       timeout_q, timeout_d;

  logic tmo_terminal;
  logic tmo_clear;
  logic tmo_enable;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    tx_data_d    = tx_data_q;
    code_stage_d = code_stage_q;
    resp_code_d  = resp_code_q;
    resp_data_d  = resp_data_q;
    timeout_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        // The command byte is latched straight into the TX data register.
        if (bus.start) begin
          state_d   = SEND_CMD;
          addr_d    = bus.address;
          tx_data_d = bus.command;
        end
      end
      SEND_CMD:  state_d = WAIT_CMD;
      WAIT_CMD: begin
        if (bus.tx_done) begin
          state_d   = SEND_ADDR;
          tx_data_d = addr_q;
        end
      end
      SEND_ADDR: state_d = WAIT_ADDR;
      WAIT_ADDR: begin
        if (bus.tx_done) state_d = WAIT_CODE;
      end
      WAIT_CODE: begin
        // Code is staged so an abort in WAIT_DATA leaves the visible response untouched.
        if (bus.rx_has_data) begin
          state_d      = WAIT_DATA;
          code_stage_d = bus.rx_data;
        end
      end
      WAIT_DATA: begin
        if (bus.rx_has_data) begin
          state_d     = DONE;
          resp_code_d = code_stage_q;
          resp_data_d = bus.rx_data;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Abort only when the awaited event did not arrive this cycle: the event wins a tie.
    if (is_wait_state(state_q) && (state_d == state_q) && tmo_terminal) begin
      state_d   = IDLE;
      timeout_d = 1'b1;
    end
  end

  assign tmo_enable = is_wait_state(state_q);
  assign tmo_clear  = (state_d != state_q);

  sensor_client_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_timeout_counter (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear    (tmo_clear),
    .enable   (tmo_enable),
    .terminal (tmo_terminal)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      addr_q       <= 8'h00;
      tx_data_q    <= 8'h00;
      code_stage_q <= 8'h00;
      resp_code_q  <= 8'h00;
      resp_data_q  <= 8'h00;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      tx_data_q    <= tx_data_d;
      code_stage_q <= code_stage_d;
      resp_code_q  <= resp_code_d;
      resp_data_q  <= resp_data_d;
      timeout_q    <= timeout_d;
    end
  end

  assign bus.busy           = (state_q != IDLE);
  assign bus.tx_has_data    = (state_q == SEND_CMD) || (state_q == SEND_ADDR);
  assign bus.tx_data        = tx_data_q;
  assign bus.response_valid = (state_q == DONE);
  assign bus.response_code  = resp_code_q;
  assign bus.response_data  = resp_data_q;
  assign bus.timeout        = timeout_q;

endmodule

// File: tb/tb_sensor_client.sv
// Purpose : randomized scoreboard bench for sensor_client with a cycle-stamped transaction model.
// Latency : n/a.
// Backpressure: n/a.
module tb_sensor_client;
  import sensor_client_pkg::*;

  localparam int TMO    = 100;
  localparam int K_TX   = 0;
  localparam int K_RESP = 1;
  localparam int K_TOUT = 2;

  typedef struct {
    int         kind;
    logic [7:0] a;
    logic [7:0] b;
    int         cyc;
  } exp_t;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   cyc     = 0;
  int   total   = 0;
  int   bad     = 0;
  bit   mon_en  = 1'b0;
  int   next_start = 0;
  exp_t exp_q[$];

  // Model of the response registers as seen from outside.
  logic [7:0] last_code = 8'h00;
  logic [7:0] last_data = 8'h00;

  sensor_client_if bus ();

  sensor_client #(
    .TIMEOUT_CYCLES (TMO),
    .CNT_W          (8)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_ev(input int kind, input logic [7:0] a, input logic [7:0] b, input int c);
    exp_t e;
    e.kind = kind;
    e.a    = a;
    e.b    = b;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic observe(input int kind, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_event: got kind %0d at cycle %0d, want no event", kind, cyc);
      return;
    end
    e = exp_q.pop_front();
    check("event_kind",  32'(kind), 32'(e.kind));
    check("event_cycle", 32'(cyc),  32'(e.cyc));
    check("event_byte_a", {24'h0, a}, {24'h0, e.a});
    check("event_byte_b", {24'h0, b}, {24'h0, e.b});
  endtask

  // Monitor: pops the scoreboard whenever the DUT emits a strobe.
  always @(negedge clock) begin
    if (mon_en) begin
      check("valid_timeout_exclusive", {31'b0, bus.response_valid & bus.timeout}, 32'd0);
      if (bus.tx_has_data === 1'b1) begin
        check("busy_during_tx", {31'b0, bus.busy}, 32'd1);
        observe(K_TX, bus.tx_data, 8'h00);
      end
      if (bus.response_valid === 1'b1) observe(K_RESP, bus.response_code, bus.response_data);
      if (bus.timeout === 1'b1) observe(K_TOUT, 8'h00, 8'h00);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
    bus.start       = 1'b0;
    bus.tx_done     = 1'b0;
    bus.rx_has_data = 1'b0;
    reset_n         = 1'b1;
  endtask

  task automatic goto(input int c);
    while (cyc < c) tick();
  endtask

  // Leaves the bench just after edge e-1 so inputs set next are sampled at edge e.
  task automatic at_edge(input int e);
    if (cyc > e - 1) begin
      total++;
      bad++;
      $display("FAIL schedule: at cycle %0d, want edge %0d", cyc, e);
    end
    goto(e - 1);
  endtask

  task automatic pulse_rx(input logic [7:0] v);
    bus.rx_has_data = 1'b1;
    bus.rx_data     = v;
  endtask

  // One transaction. w0..w3: edges after entering each wait stage at which the awaited
  // event arrives; a value above TMO means the event never comes.
  task automatic run_txn(input logic [7:0] cmd, input logic [7:0] addr,
                         input logic [7:0] code, input logic [7:0] data,
                         input int w0, input int w1, input int w2, input int w3,
                         input bit stray);
    int ws[4];
    int s, entry, ev;
    ws = '{w0, w1, w2, w3};
    ev = 0;
    s  = next_start + int'($urandom_range(0, 2));
    if (s > next_start) begin
      at_edge(next_start);
      pulse_rx(8'hAA);
    end
    expect_ev(K_TX, cmd, 8'h00, s);
    at_edge(s);
    bus.start   = 1'b1;
    bus.command = cmd;
    bus.address = addr;
    entry = s + 1;
    for (int st = 0; st < 4; st++) begin
      if (ws[st] > TMO) begin
        expect_ev(K_TOUT, 8'h00, 8'h00, entry + TMO);
        goto(entry + TMO);
        check("busy_after_timeout", {31'b0, bus.busy}, 32'd0);
        check("code_kept_on_timeout", {24'h0, bus.response_code}, {24'h0, last_code});
        check("data_kept_on_timeout", {24'h0, bus.response_data}, {24'h0, last_data});
        next_start = entry + TMO + 1;
        return;
      end
      ev = entry + ws[st];
      if (stray && st == 0 && ws[st] >= 2) begin
        at_edge(entry + 1);
        pulse_rx(8'hAA);
      end
      if (stray && st == 1 && ws[st] >= 2) begin
        at_edge(entry + 1);
        bus.start   = 1'b1;
        bus.command = ~cmd;
        bus.address = ~addr;
      end
      case (st)
        0: begin
          expect_ev(K_TX, addr, 8'h00, ev);
          at_edge(ev);
          bus.tx_done = 1'b1;
          entry = ev + 1;
        end
        1: begin
          at_edge(ev);
          bus.tx_done = 1'b1;
          entry = ev;
        end
        2: begin
          at_edge(ev);
          pulse_rx(code);
          entry = ev;
        end
        default: begin
          expect_ev(K_RESP, code, data, ev);
          at_edge(ev);
          pulse_rx(data);
          last_code = code;
          last_data = data;
        end
      endcase
    end
    goto(ev + 1);
    check("busy_after_done", {31'b0, bus.busy}, 32'd0);
    check("tx_data_holds", {24'h0, bus.tx_data}, {24'h0, addr});
    check("code_after_done", {24'h0, bus.response_code}, {24'h0, last_code});
    check("data_after_done", {24'h0, bus.response_data}, {24'h0, last_data});
    next_start = ev + 2;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"},  {31'b0, bus.busy}, 32'd0);
    check({tag, "_tx_has_data"}, {31'b0, bus.tx_has_data}, 32'd0);
    check({tag, "_tx_data"}, {24'h0, bus.tx_data}, 32'd0);
    check({tag, "_response_valid"}, {31'b0, bus.response_valid}, 32'd0);
    check({tag, "_response_code"}, {24'h0, bus.response_code}, 32'd0);
    check({tag, "_response_data"}, {24'h0, bus.response_data}, 32'd0);
    check({tag, "_timeout"}, {31'b0, bus.timeout}, 32'd0);
  endtask

  // Reset asserted k edges after the code byte lands in WAIT_DATA.
  task automatic run_reset_case(input logic [7:0] cmd, input logic [7:0] addr,
                                input logic [7:0] code, input int k);
    int s, e0, e1, e2, r;
    s  = next_start;
    e0 = s + 1 + 3;
    e1 = e0 + 1 + 4;
    e2 = e1 + 2;
    r  = e2 + k;
    expect_ev(K_TX, cmd, 8'h00, s);
    at_edge(s);
    bus.start   = 1'b1;
    bus.command = cmd;
    bus.address = addr;
    expect_ev(K_TX, addr, 8'h00, e0);
    at_edge(e0);
    bus.tx_done = 1'b1;
    at_edge(e1);
    bus.tx_done = 1'b1;
    at_edge(e2);
    pulse_rx(code);
    at_edge(r);
    reset_n = 1'b0;
    goto(r);
    check_reset_values("mid_reset");
    last_code = 8'h00;
    last_data = 8'h00;
    // The data byte arriving after reset must be ignored.
    at_edge(r + 1);
    pulse_rx(8'h5C);
    next_start = r + 2;
  endtask

  initial begin
    int w[4];
    logic [7:0] c, a, rc, rd;
    bit st;

    bus.start       = 1'b0;
    bus.command     = 8'h00;
    bus.address     = 8'h00;
    bus.tx_done     = 1'b0;
    bus.rx_has_data = 1'b0;
    bus.rx_data     = 8'h00;
    reset_n         = 1'b0;

    repeat (3) @(posedge clock);
    #1;
    check_reset_values("reset");
    reset_n    = 1'b1;
    mon_en     = 1'b1;
    next_start = cyc + 1;

    // Normal request: tx_done ten cycles after each strobe.
    run_txn(CMD_TEMPERATURE, 8'h05, 8'h02, 8'h1A, 9, 9, 6, 4, 1'b0);
    // No reply at all after both bytes are sent.
    run_txn(CMD_TEMPERATURE, 8'h05, 8'h77, 8'h88, 9, 9, TMO + 1, 1, 1'b0);
    // Stray rx byte in WAIT_CMD and stray start in WAIT_ADDR.
    run_txn(CMD_HUMIDITY, 8'h07, 8'h11, 8'h22, 5, 6, 3, 2, 1'b1);
    // Second rx byte on the terminal-count cycle.
    run_txn(CMD_STATUS, 8'h09, 8'h33, 8'h44, 4, 4, 4, TMO, 1'b0);
    // One cycle too late: timeout, staged code must not leak out.
    run_txn(CMD_STATUS, 8'h0A, 8'h55, 8'h66, 4, 4, 4, TMO + 1, 1'b0);
    // Tx completion exactly on the terminal edge, then timeout waiting for tx.
    run_txn(CMD_HUMIDITY, 8'h0C, 8'h12, 8'h34, TMO, 3, 2, 2, 1'b0);
    run_txn(CMD_HUMIDITY, 8'h0D, 8'h12, 8'h34, TMO + 1, 3, 2, 2, 1'b0);
    // Reset mid-transaction, then a normal request.
    run_reset_case(CMD_STATUS, 8'h0B, 8'h03, 3);
    run_txn(CMD_TEMPERATURE, 8'h05, 8'h02, 8'h1A, 9, 9, 2, 2, 1'b0);

    for (int i = 0; i < 24; i++) begin
      for (int j = 0; j < 4; j++) begin
        case ($urandom_range(0, 9))
          0:       w[j] = TMO + 1;
          1:       w[j] = TMO;
          2:       w[j] = TMO - 1;
          default: w[j] = int'($urandom_range(1, 25));
        endcase
      end
      case ($urandom_range(0, 3))
        0:       c = CMD_TEMPERATURE;
        1:       c = CMD_HUMIDITY;
        2:       c = CMD_STATUS;
        default: c = 8'($urandom());
      endcase
      a  = 8'($urandom());
      rc = 8'($urandom());
      rd = 8'($urandom());
      st = 1'($urandom_range(0, 1));
      run_txn(c, a, rc, rd, w[0], w[1], w[2], w[3], st);
    end

    goto(cyc + 10);
    check("pending_expectations", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
